// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
// Snapshots a complete parallel frame and replays it as a raster-order 8-bit
// pixel stream with a valid/ready handshake and frame/line markers.
//
// Parameters:
//   HEIGHT, WIDTH  frame rows / columns
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   frame_in[r][c]      parallel frame, sampled when frame_in_valid && frame_in_ready
//   frame_in_valid      frame_in holds a complete frame
//   frame_in_ready      block is idle and will take a frame (registered)
//   m_pixel/m_valid/m_ready   output beat handshake
//   m_sof/m_eol/m_eof   first pixel / last column / last pixel markers
//   busy                a frame is being streamed
//   frame_count         frames fully streamed since reset (wraps)
// Optional feature:
//   FRAME_STREAM_BORDER_ZERO_EN  forces border pixels of every frame to 8'd0
module frame_pixel_streamer #(
  parameter int unsigned HEIGHT = 50,
  parameter int unsigned WIDTH  = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  frame_in [HEIGHT-1:0][WIDTH-1:0],
  input  logic        frame_in_valid,
  output logic        frame_in_ready,
  output logic [7:0]  m_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          load;
  logic          frame_done;
  logic [7:0]    pix_d;
  logic [7:0]    buffer [HEIGHT-1:0][WIDTH-1:0];

  // Next state, next raster index and the pixel that index selects.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    load       = 1'b0;
    frame_done = 1'b0;
    pix_d      = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (frame_in_valid && frame_in_ready) begin
          load    = 1'b1;
          state_d = ST_STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_STREAM: begin
        if (m_valid && m_ready) begin
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
            row_d      = '0;
            col_d      = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // First beat comes straight from the port since the buffer is loading now.
    pix_d = load ? frame_in[0][0] : buffer[row_d][col_d];
`ifdef FRAME_STREAM_BORDER_ZERO_EN
    if (row_d == '0 || row_d == ROW_LAST || col_d == '0 || col_d == COL_LAST)
      pix_d = 8'd0;
`endif
  end

  // Frame snapshot; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (load) buffer <= frame_in;
  end

  // State, indices and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      row_q          <= '0;
      col_q          <= '0;
      frame_in_ready <= 1'b0;
      m_valid        <= 1'b0;
      m_pixel        <= 8'd0;
      m_sof          <= 1'b0;
      m_eol          <= 1'b0;
      m_eof          <= 1'b0;
      busy           <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      frame_in_ready <= (state_d == ST_IDLE);
      m_valid        <= (state_d == ST_STREAM);
      busy           <= (state_d == ST_STREAM);
      if (state_d == ST_STREAM) begin
        m_pixel <= pix_d;
        m_sof   <= (row_d == '0) && (col_d == '0);
        m_eol   <= (col_d == COL_LAST);
        m_eof   <= (row_d == ROW_LAST) && (col_d == COL_LAST);
      end else begin
        m_pixel <= 8'd0;
        m_sof   <= 1'b0;
        m_eol   <= 1'b0;
        m_eof   <= 1'b0;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Converts a full parallel frame, e.g. edge_detector image_out/image_out_valid, into a raster-order 8-bit pixel stream with valid/ready handshake and frame/line markers.
- Sits downstream of the edge-detection pipeline and feeds any byte-serial consumer: output DMA, UART bridge, or a file-dump monitor in sim.
- Snapshots the frame on acceptance, so the upstream producer is free immediately.

Parameters:
- HEIGHT, 50, frame rows.
- WIDTH, 50, frame columns.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- frame_in  input  [7:0] x [HEIGHT-1:0][WIDTH-1:0]  unpacked pixel array, [row][col].
- frame_in_valid  input  1  frame_in holds a complete frame.
- frame_in_ready  output  1  block can accept a frame.
- m_pixel  output  8  current pixel.
- m_valid  output  1  m_pixel and flags are valid.
- m_ready  input  1  consumer accepts the current beat.
- m_sof  output  1  beat is pixel (0,0).
- m_eol  output  1  beat is the last column of its row.
- m_eof  output  1  beat is pixel (HEIGHT-1, WIDTH-1).
- busy  output  1  a frame is being streamed.
- frame_count  output  16  frames fully streamed since reset; wraps 0xFFFF->0.

Behaviour:
- Reset values (any cycle reset_n=0 at posedge): state=IDLE, frame_in_ready=0, m_valid=0, m_pixel=0, m_sof=m_eol=m_eof=0, busy=0, frame_count=0, row=col=0. Frame buffer contents are don't-care.
- frame_in_ready is registered. It is 1 from the first cycle after reset deasserts whenever state=IDLE.
- FSM states: IDLE, STREAM.
- IDLE:
  - frame_in_ready=1, m_valid=0.
  - On frame_in_valid && frame_in_ready: copy all HEIGHT*WIDTH pixels into the internal buffer, row=col=0, go to STREAM.
  - frame_in_ready=0 and m_valid=1 from the next cycle. Latency is exactly 1 cycle from accept to first beat.
- STREAM:
  - m_valid=1 continuously.
  - m_pixel=buffer[row][col].
  - m_sof=(row==0 && col==0).
  - m_eol=(col==WIDTH-1).
  - m_eof=(row==HEIGHT-1 && col==WIDTH-1).
- Beat transfer: a beat transfers on m_valid && m_ready.
  - On transfer, col increments.
  - At col==WIDTH-1, col wraps to 0 and row increments.
- End of frame: transfer of the m_eof beat causes the following next cycle:
  - state=IDLE, m_valid=0, frame_in_ready=1, flags=0, frame_count+1, row=col=0.
- Stall rule: while m_valid && !m_ready, m_pixel and all flags hold stable. No beat is dropped or duplicated.
- No combinational path from m_ready to m_valid or frame_in_ready. All outputs derive from registered state/indices plus the buffer.
- frame_in_valid is ignored during STREAM because frame_in_ready=0. Changes to frame_in after acceptance do not affect the stream.
- busy = (state==STREAM).
- Throughput with m_ready tied high: HEIGHT*WIDTH beats per frame plus 1 IDLE accept cycle between frames.
- Degenerate sizes:
  - WIDTH=1: m_eol=1 on every beat.
  - HEIGHT=WIDTH=1: m_sof, m_eol and m_eof all 1 on the single beat.
- Reset mid-frame aborts the stream immediately; no partial-frame count.

Optional Feature:
- Macro: FRAME_STREAM_BORDER_ZERO_EN.
- Defined: any beat with row==0, row==HEIGHT-1, col==0 or col==WIDTH-1 outputs m_pixel=8'd0, which masks convolution border artefacts. Flags and timing are unchanged.
- Undefined: border pixels stream unmodified.

Test Plan:
- HEIGHT=4, WIDTH=4, pixel[r][c]=16r+c, m_ready=1:
  - 16 beats 0x00..0x33 in raster order.
  - m_sof on beat 0; m_eol on beats 3,7,11,15; m_eof on beat 15.
  - First m_valid 1 cycle after accept; frame_count=1.
- Same frame, m_ready toggling 1/0 each cycle plus a 5-cycle stall at beat 6:
  - m_pixel holds 0x12 through the stall.
  - Sequence identical to the previous test; no drops or duplicates.
- Accept frame A (all 0xAA), then change frame_in to all 0x55 with frame_in_valid=1 during STREAM:
  - All 16 beats read 0xAA; frame_in_ready=0 throughout.
  - frame B is accepted the first cycle after A's m_eof transfer.
- Assert reset_n=0 at beat 9:
  - Next cycle m_valid=0, frame_count=0.
  - After release, a new frame streams from (0,0) with m_sof=1.
- HEIGHT=WIDTH=1, pixel 0x7F: single beat 0x7F with m_sof=m_eol=m_eof=1; frame_count=1.
- FRAME_STREAM_BORDER_ZERO_EN defined, 4x4 all 0xFF: only beats 5,6,9,10 read 0xFF, all others 0x00.
